pic_reg_ctl: RTL and testbench

Memory-mapped PIC register responder and external-interrupt arbiter. It services the LSU's PIC port: reads and mask fetches issued in DC1 return data in DC2, and store-buffer writes are applied at the clock edge. It also holds per-source gateway, priority and enable state. Every cycle it publishes a registered best-interrupt claim to the core.

---
 rtl/pic_pkg.sv | 35 +++
 rtl/pic_gateway.sv | 54 +++++
 rtl/pic_reg_ctl.sv | 184 ++++++++++++++++++
 tb/tb_pic_reg_ctl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pic_pkg
//  Purpose  : Shared definitions for the PIC register responder: register
//             offsets (picm_addr[14:0] with the source field cleared), the
//             per-register writable masks and the gateway configuration type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

  // Register block bases; per-source registers add 4*S.
  localparam logic [14:0] MEIPL_OFF     = 15'h0000;
  localparam logic [14:0] MEIP_OFF      = 15'h1000;
  localparam logic [14:0] MEIE_OFF      = 15'h2000;
  localparam logic [14:0] MPICCFG_OFF   = 15'h3000;
  localparam logic [14:0] MEIGWCTRL_OFF = 15'h4000;
  localparam logic [14:0] MEIGWCLR_OFF  = 15'h5000;

  // Writable-bit masks returned on a mask fetch.
  localparam logic [31:0] MEIPL_MASK     = 32'h0000_000F;
  localparam logic [31:0] MEIP_MASK      = 32'h0000_0000;
  localparam logic [31:0] MEIE_MASK      = 32'h0000_0001;
  localparam logic [31:0] MPICCFG_MASK   = 32'h0000_0001;
  localparam logic [31:0] MEIGWCTRL_MASK = 32'h0000_0003;
  localparam logic [31:0] MEIGWCLR_MASK  = 32'h0000_0000;

  // Field order matches the register layout: bit1 = type, bit0 = polarity.
  typedef struct packed {
    logic edge_type;  // 1 = edge-triggered
    logic polarity;   // 1 = active-low
  } gw_cfg_t;

endpackage
`default_nettype wire

// File: rtl/pic_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : pic_gateway
//  Purpose  : Per-source interrupt gateway: two-flop synchronizer, polarity
//             inversion and an edge latch with software clear.
//  Ports    : clk, rst_l     - clock, synchronous active-low reset
//             req            - raw asynchronous request
//             cfg            - polarity / type configuration
//             clr            - one-cycle meigwclr write strobe
//             pend           - qualified pending level
//  Revision : 1.0 - initial release
// ============================================================================
module pic_gateway
  import pic_pkg::*;
(
  input  logic    clk,
  input  logic    rst_l,
  input  logic    req,
  input  gw_cfg_t cfg,
  input  logic    clr,
  output logic    pend
);

  logic sync1;
  logic sync2;
  logic latch;
  logic req_s;

  assign req_s = sync2 ^ cfg.polarity;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      latch <= 1'b0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
      // The latch is held clear in level mode, so any change of type
      // always leaves it cleared. In edge mode a set beats a clear.
      if (!cfg.edge_type) begin
        latch <= 1'b0;
      end else if (req_s) begin
        latch <= 1'b1;
      end else if (clr) begin
        latch <= 1'b0;
      end
    end
  end

  assign pend = cfg.edge_type ? (latch | req_s) : req_s;

endmodule
`default_nettype wire

// File: rtl/pic_reg_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : pic_reg_ctl
//  Purpose  : Memory-mapped PIC register responder and external-interrupt
//             arbiter with registered claim outputs.
//  Ports    : clk, rst_l                 - clock, synchronous active-low reset
//             picm_rden/mken/wren        - read, mask fetch, write requests
//             picm_addr, picm_wr_data    - access address and write data
//             picm_rd_data               - registered read / mask data
//             extintsrc_req              - async requests, bit i-1 = source i
//             meipt, meicurpl            - threshold and current priority
//             mexintpend, claimid, pl    - registered best-interrupt claim
//  Revision : 1.0 - initial release
// ============================================================================
module pic_reg_ctl
  import pic_pkg::*;
#(
  parameter int TOTAL_INT = 8
)(
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 picm_rden,
  input  logic                 picm_mken,
  input  logic                 picm_wren,
  input  logic [31:0]          picm_addr,
  input  logic [31:0]          picm_wr_data,
  output logic [31:0]          picm_rd_data,
  input  logic [TOTAL_INT-1:0] extintsrc_req,
  input  logic [3:0]           meipt,
  input  logic [3:0]           meicurpl,
  output logic                 mexintpend,
  output logic [7:0]           claimid,
  output logic [3:0]           pl
);

  localparam logic [4:0] MAX_SRC = 5'(TOTAL_INT);

  logic [3:0]     meipl   [1:TOTAL_INT];
  logic           meie    [1:TOTAL_INT];
  gw_cfg_t        gw_cfg  [1:TOTAL_INT];
  logic           rev;
  logic [TOTAL_INT:1] pend;
  logic [TOTAL_INT:1] gw_clr;

  // ---------------------------------------------------------------- decode
  logic [14:0] off;
  logic [14:0] base;
  logic [4:0]  src;
  logic        src_ok;
  logic        glb_ok;
  logic        wr_ok;
  logic        unused_bits;

  assign off    = picm_addr[14:0];
  assign base   = {off[14:12], 12'h000};
  assign src    = off[6:2];
  assign src_ok = (off[11:7] == 5'd0) && (src != 5'd0) && (src <= MAX_SRC);
  assign glb_ok = (off[11:2] == 10'd0);
  // A concurrent read or mask fetch wins over a write.
  assign wr_ok  = picm_wren & ~picm_rden & ~picm_mken;
  assign unused_bits = ^{picm_addr[31:15], picm_addr[1:0], picm_wr_data[31:4]};

  // ------------------------------------------------------- read/mask value
  logic [31:0] rd_val;
  logic [31:0] mask_val;

  always_comb begin
    rd_val   = '0;
    mask_val = '0;
    if (src_ok) begin
      for (int i = 1; i <= TOTAL_INT; i++) begin
        if (src == 5'(i)) begin
          case (base)
            MEIPL_OFF:     begin rd_val = {28'd0, meipl[i]};  mask_val = MEIPL_MASK;     end
            MEIE_OFF:      begin rd_val = {31'd0, meie[i]};   mask_val = MEIE_MASK;      end
            MEIGWCTRL_OFF: begin rd_val = {30'd0, gw_cfg[i]}; mask_val = MEIGWCTRL_MASK; end
            MEIGWCLR_OFF:  begin rd_val = '0;                 mask_val = MEIGWCLR_MASK;  end
            default:       ;
          endcase
        end
      end
    end else if (glb_ok) begin
      case (base)
        MEIP_OFF:    begin rd_val = 32'({pend, 1'b0}); mask_val = MEIP_MASK;    end
        MPICCFG_OFF: begin rd_val = {31'd0, rev};      mask_val = MPICCFG_MASK; end
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      picm_rd_data <= '0;
    end else if (picm_rden) begin
      picm_rd_data <= rd_val;
    end else if (picm_mken) begin
      picm_rd_data <= mask_val;
    end
  end

  // ---------------------------------------------------------------- writes
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rev <= 1'b0;
      for (int i = 1; i <= TOTAL_INT; i++) begin
        meipl[i]  <= '0;
        meie[i]   <= 1'b0;
        gw_cfg[i] <= '0;
      end
    end else if (wr_ok) begin
      if (glb_ok && (base == MPICCFG_OFF)) begin
        rev <= picm_wr_data[0] & MPICCFG_MASK[0];
      end
      for (int i = 1; i <= TOTAL_INT; i++) begin
        if (src_ok && (src == 5'(i))) begin
          case (base)
            MEIPL_OFF:     meipl[i]  <= picm_wr_data[3:0] & MEIPL_MASK[3:0];
            MEIE_OFF:      meie[i]   <= picm_wr_data[0] & MEIE_MASK[0];
            MEIGWCTRL_OFF: gw_cfg[i] <= gw_cfg_t'(picm_wr_data[1:0] & MEIGWCTRL_MASK[1:0]);
            default:       ;
          endcase
        end
      end
    end
  end

  // -------------------------------------------------------------- gateways
  generate
    for (genvar g = 1; g <= TOTAL_INT; g++) begin : g_gw
      assign gw_clr[g] = wr_ok && src_ok && (base == MEIGWCLR_OFF) && (src == 5'(g));

      pic_gateway u_gw (
        .clk   (clk),
        .rst_l (rst_l),
        .req   (extintsrc_req[g-1]),
        .cfg   (gw_cfg[g]),
        .clr   (gw_clr[g]),
        .pend  (pend[g])
      );
    end
  endgenerate

  // ----------------------------------------------------------- arbitration
  // Starting from the "never wins" priority and requiring a strict
  // improvement gives both the exclusion and lowest-ID tie-breaking.
  logic [3:0] best_pl;
  logic [7:0] best_id;
  logic [3:0] thresh;
  logic       qual;

  always_comb begin
    best_pl = rev ? 4'hF : 4'h0;
    best_id = 8'd0;
    for (int i = 1; i <= TOTAL_INT; i++) begin
      if (pend[i] && meie[i]) begin
        if (rev ? (meipl[i] < best_pl) : (meipl[i] > best_pl)) begin
          best_pl = meipl[i];
          best_id = 8'(i);
        end
      end
    end
    if (rev) begin
      thresh = (meipt < meicurpl) ? meipt : meicurpl;
      qual   = (best_id != 8'd0) && (best_pl < thresh);
    end else begin
      thresh = (meipt > meicurpl) ? meipt : meicurpl;
      qual   = (best_id != 8'd0) && (best_pl > thresh);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      mexintpend <= 1'b0;
      claimid    <= '0;
      pl         <= '0;
    end else begin
      mexintpend <= qual;
      claimid    <= best_id;
      pl         <= best_pl;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pic_reg_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pic_reg_ctl
//  Purpose  : Directed self-checking bench for pic_reg_ctl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pic_reg_ctl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        picm_rden, picm_mken, picm_wren;
  logic [31:0] picm_addr, picm_wr_data, picm_rd_data;
  logic [7:0]  extintsrc_req;
  logic [3:0]  meipt, meicurpl, pl;
  logic        mexintpend;
  logic [7:0]  claimid;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  pic_reg_ctl #(.TOTAL_INT(8)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .picm_rden     (picm_rden),
    .picm_mken     (picm_mken),
    .picm_wren     (picm_wren),
    .picm_addr     (picm_addr),
    .picm_wr_data  (picm_wr_data),
    .picm_rd_data  (picm_rd_data),
    .extintsrc_req (extintsrc_req),
    .meipt         (meipt),
    .meicurpl      (meicurpl),
    .mexintpend    (mexintpend),
    .claimid       (claimid),
    .pl            (pl)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    picm_wren = 1'b1; picm_addr = addr; picm_wr_data = data;
    @(negedge clk);
    picm_wren = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    picm_rden = 1'b1; picm_addr = addr;
    @(posedge clk); #1;
    data = picm_rd_data;
    picm_rden = 1'b0;
  endtask

  task automatic mask_reg(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    picm_mken = 1'b1; picm_addr = addr;
    @(posedge clk); #1;
    data = picm_rd_data;
    picm_mken = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; picm_rden = 0; picm_mken = 0; picm_wren = 0;
    picm_addr = 0; picm_wr_data = 0; extintsrc_req = 0; meipt = 0; meicurpl = 0;
    cycles(3);
    @(negedge clk) rst_l = 1'b1;

    // reset state
    check_val("rst_claimid", 32'(claimid), 0);
    check_val("rst_mexintpend", 32'(mexintpend), 0);
    check_val("rst_rd_data", picm_rd_data, 0);
    read_reg(32'h000C, rd); check_val("rst_meipl3", rd, 0);
    read_reg(32'h200C, rd); check_val("rst_meie3", rd, 0);
    read_reg(32'h3000, rd); check_val("rst_mpiccfg", rd, 0);
    read_reg(32'h1000, rd); check_val("rst_meip", rd, 0);

    // mask fetches and decode
    mask_reg(32'h4008, rd); check_val("mask_gwctrl2", rd, 32'h3);
    mask_reg(32'h1000, rd); check_val("mask_meip", rd, 32'h0);
    mask_reg(32'h0008, rd); check_val("mask_meipl2", rd, 32'hF);
    mask_reg(32'h0024, rd); check_val("mask_src9", rd, 32'h0);
    write_reg(32'h0004, 32'hFFFF_FFFF);
    read_reg(32'h0004, rd); check_val("wr_meipl1_masked", rd, 32'hF);
    write_reg(32'h0000, 32'hF);
    read_reg(32'h0000, rd); check_val("wr_src0", rd, 32'h0);
    write_reg(32'h6000, 32'hF);
    read_reg(32'h6000, rd); check_val("wr_unmapped", rd, 32'h0);

    // level arbitration
    write_reg(32'h0008, 32'h5);
    write_reg(32'h0014, 32'h5);
    write_reg(32'h2008, 32'h1);
    write_reg(32'h2014, 32'h1);
    meipt = 4'd3;
    @(negedge clk) extintsrc_req = 8'b0001_0010;
    cycles(2);
    check_val("lvl_claim_edge1", 32'(claimid), 0);
    cycles(1);
    check_val("lvl_claimid", 32'(claimid), 2);
    check_val("lvl_pl", 32'(pl), 5);
    check_val("lvl_mexintpend", 32'(mexintpend), 1);
    @(negedge clk) meicurpl = 4'd5;
    cycles(1);
    check_val("lvl_curpl_block", 32'(mexintpend), 0);
    @(negedge clk) meicurpl = 4'd0;
    write_reg(32'h2008, 32'h0);
    check_val("meie_wr_edgeN", 32'(claimid), 2);
    cycles(1);
    check_val("meie_wr_edgeN1", 32'(claimid), 5);
    check_val("meie_wr_pl", 32'(pl), 5);
    @(negedge clk) extintsrc_req = 8'h00;
    cycles(4);

    // edge gateway on source 4
    write_reg(32'h4010, 32'h2);
    @(negedge clk) extintsrc_req = 8'b0000_1000;
    @(negedge clk) extintsrc_req = 8'h00;
    cycles(4);
    read_reg(32'h1000, rd); check_val("edge_latched", rd, 32'h10);
    write_reg(32'h5010, 32'h0);
    read_reg(32'h1000, rd); check_val("edge_cleared", rd, 32'h00);
    @(negedge clk) extintsrc_req = 8'b0000_1000;
    cycles(3);
    write_reg(32'h5010, 32'h0);
    read_reg(32'h1000, rd); check_val("edge_clr_while_high", rd, 32'h10);
    @(negedge clk) extintsrc_req = 8'h00;
    cycles(4);
    read_reg(32'h1000, rd); check_val("edge_held_after_drop", rd, 32'h10);
    write_reg(32'h5010, 32'h0);
    read_reg(32'h1000, rd); check_val("edge_final_clear", rd, 32'h00);
    write_reg(32'h4010, 32'h0);

    // reverse order
    write_reg(32'h3000, 32'h1);
    write_reg(32'h0004, 32'h2);
    write_reg(32'h000C, 32'h0);
    write_reg(32'h2004, 32'h1);
    write_reg(32'h200C, 32'h1);
    read_reg(32'h3000, rd); check_val("rev_cfg", rd, 32'h1);
    meipt = 4'd0;
    @(negedge clk) extintsrc_req = 8'b0000_0101;
    cycles(4);
    check_val("rev_claimid", 32'(claimid), 3);
    check_val("rev_pl", 32'(pl), 0);
    check_val("rev_mexintpend_thr0", 32'(mexintpend), 0);
    @(negedge clk) begin meipt = 4'd4; meicurpl = 4'd4; end
    cycles(1);
    check_val("rev_mexintpend_thr4", 32'(mexintpend), 1);
    @(negedge clk) extintsrc_req = 8'h00;
    cycles(4);
    check_val("rev_none_claimid", 32'(claimid), 0);
    check_val("rev_none_pl", 32'(pl), 15);

    // read/write conflict, read priority, hold, reset mid-read
    @(negedge clk);
    picm_rden = 1; picm_wren = 1; picm_addr = 32'h0008; picm_wr_data = 32'h9;
    @(posedge clk); #1;
    check_val("conflict_old", picm_rd_data, 32'h5);
    picm_rden = 0; picm_wren = 0;
    read_reg(32'h0008, rd); check_val("conflict_dropped", rd, 32'h5);
    @(negedge clk);
    picm_rden = 1; picm_mken = 1; picm_addr = 32'h0008;
    @(posedge clk); #1;
    check_val("rden_over_mken", picm_rd_data, 32'h5);
    picm_rden = 0; picm_mken = 0;
    write_reg(32'h2004, 32'h0);
    check_val("hold_on_write", picm_rd_data, 32'h5);
    @(negedge clk);
    picm_rden = 1; picm_addr = 32'h0008; rst_l = 0;
    @(posedge clk); #1;
    check_val("rst_mid_read", picm_rd_data, 32'h0);
    check_val("rst_mid_pl", 32'(pl), 0);
    picm_rden = 0;
    @(negedge clk) rst_l = 1;
    read_reg(32'h0008, rd); check_val("post_rst_meipl2", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
